systolic_skew_feeder: RTL and testbench
=======================================

Name: systolic_skew_feeder

Overview:
- Upstream feeder for the 3x3 systolic PE array.
- Buffers packed activation vectors, one element per array row, written by the wishbone front-end.
- On start, streams them into the array's left edge with diagonal skew: row r is delayed r cycles.
- Holds en high with zero padding until the last partial sums have left the bottom row, then pulses done.

Parameters:
- ELEM_W, 8, element width in bits (left-edge operand width of pe).
- ROWS, 3, number of array rows and elements per vector.
- DEPTH, 8, vector buffer capacity in vectors.
- AWIDTH, 3, buffer address width; must equal clog2(DEPTH).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- s_valid  in  1  input vector valid.
- s_ready  out  1  feeder can accept a vector.
- s_data  in  ROWS*ELEM_W  packed vector; row r element in bits [r*ELEM_W +: ELEM_W].
- s_last  in  1  marks the final vector of a batch; acts as an implicit start.
- start  in  1  single-cycle request to stream the buffered vectors.
- row_data  out  ROWS*ELEM_W  skewed left-edge operands; same packing as s_data.
- en_o  out  1  array enable, drives pe en.
- busy  out  1  high in STREAM or FLUSH.
- done  out  1  one-cycle pulse when a batch has fully drained.
- vec_count  out  AWIDTH+1  number of vectors currently buffered.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: row_data=0, en_o=0, busy=0, done=0, vec_count=0, s_ready=1. State goes to IDLE; read/write pointers and all delay lines clear.
- Reset asserted mid-stream aborts the batch immediately; no done pulse.
- States:
  - IDLE: accepts vectors. Exits to STREAM when start, or an accepted s_last, is seen and vec_count (including any vector accepted that cycle) is >0.
  - STREAM: reads one vector per cycle for N=vec_count cycles, feeding the delay lines.
  - FLUSH: feeds zeros for 2*ROWS-1 cycles.
  - DONE_ST: one cycle; done=1; returns to IDLE.
- start with N=0: no STREAM, no en_o. done pulses in the cycle after start.
- Accept condition: s_valid && s_ready. s_ready = (state==IDLE) && (vec_count<DEPTH).
- Buffer full: s_ready=0, and s_data is ignored.
- Vectors offered while busy are not accepted; the upstream holds them.
- start or s_last while busy is ignored.
- Start and s_valid in the same IDLE cycle: the vector is accepted and included in the batch.
- Skew: let k be the STREAM cycle index (0..N-1) and vec[j] the j-th buffered vector.
  - Row r of row_data at output cycle t is vec[t-r][r] when 0<=t-r<N, else 0.
  - Row 0 passes through one register; row r passes through 1+r registers.
- Latency: output cycle t=0 is the second clock cycle after the cycle in which start (or accepted s_last) is high.
- en_o is high for exactly N+2*ROWS-1 consecutive cycles, aligned with row_data.
- done is asserted in the cycle after the last en_o cycle.
- busy is high from the cycle after the trigger through the last en_o cycle.
- On done, vec_count returns to 0 and the pointers reset (see Optional Feature).
- No arithmetic is performed. The pointers do not wrap within a batch because N<=DEPTH.

Optional Feature:
- Macro: FEEDER_REPLAY_EN.
- Defined:
  - Buffer contents and vec_count are retained after done.
  - A later start replays the same N vectors, so one input set can be applied against several weight loads.
  - Asserting s_valid with s_ready in IDLE after a completed batch clears the buffer first; that vector becomes vec[0].
  - rst still clears everything.
- Not defined: the buffer is emptied on done as described above.

Decomposition:
- Shared package npu_pkg:
  - ELEM_W, ROWS and PSUM_W=16 constants.
  - feeder_state_t enum: IDLE, STREAM, FLUSH, DONE_ST.
  - FLUSH_CYC=2*ROWS-1 constant.
- Sub-module skew_delay: per-row delay line parameterized by DELAY, with synchronous clear. Instantiated ROWS times via generate, using DELAY=r.

Test Plan:
- Basic skew: ROWS=3, push v0=0x030201 and v1=0x060504 with s_last on v1 -> row_data over en cycles: 0x000001, 0x000204, 0x030500, 0x060000, then 0x000000 x3; en_o high 7 cycles; done one cycle later; vec_count=0.
- Full buffer: push 9 vectors with s_valid held -> s_ready falls after the 8th; vec_count=8; 9th not accepted. start -> en_o high 13 cycles.
- Empty start: start with vec_count=0 -> en_o never high; done pulses exactly one cycle later.
- Backpressure/ignore: during STREAM, drive s_valid=1 and pulse start -> s_ready=0, no extra vectors, timing unchanged, single done.
- Reset mid-operation: assert rst at STREAM cycle 1 -> next cycle row_data=0, en_o=0, busy=0, vec_count=0; no done.
- Replay (FEEDER_REPLAY_EN): after the basic test, pulse start again -> identical 7-cycle sequence; vec_count stays 2. Without the macro -> empty-start behaviour.

Source files
------------

// File: rtl/npu_pkg.sv
// Shared constants and types for the NPU datapath blocks.
//   ELEM_W    : left-edge operand width of a PE
//   ROWS      : systolic array rows (and columns)
//   PSUM_W    : partial-sum width
//   FLUSH_CYC : zero-padding cycles needed to drain the array after the last vector
package npu_pkg;

   localparam int unsigned ELEM_W    = 8;
   localparam int unsigned ROWS      = 3;
   localparam int unsigned PSUM_W    = 16;
   localparam int unsigned FLUSH_CYC = 2 * ROWS - 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      STREAM  = 2'd1,
      FLUSH   = 2'd2,
      DONE_ST = 2'd3
   } feeder_state_t;

endpackage

// File: rtl/skew_delay.sv
// Per-row skew delay line: one capture register followed by DELAY further
// registers, so the output lags the input by DELAY+1 cycles.
// Ports:
//   clk, rst : clock, synchronous active-high clear of every stage
//   d        : element entering the line
//   q        : element leaving the line (registered)
module skew_delay #(
   parameter int unsigned W     = 8,
   parameter int unsigned DELAY = 0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] stage [DELAY+1];

   // Shift chain; stage[0] is the capture register shared by every row.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i <= int'(DELAY); i++) stage[i] <= '0;
      end else begin
         stage[0] <= d;
         for (int i = 1; i <= int'(DELAY); i++) stage[i] <= stage[i-1];
      end
   end

   assign q = stage[DELAY];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Left-edge feeder for the systolic PE array. Buffers up to DEPTH packed
// activation vectors, then streams them with a diagonal skew (row r delayed
// r cycles), pads with zeros until the array has drained, and pulses done.
// Build option: define FEEDER_REPLAY_EN to keep the buffer after done so a
// later start replays the same batch; a new accepted vector wipes it first.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   s_valid/s_ready   : vector write handshake, s_data packed row-major
//   s_last            : final vector of a batch, doubles as a start
//   start             : stream the buffered vectors
//   row_data, en_o    : skewed operands and array enable
//   busy, done        : batch in progress / one-cycle drained pulse
//   vec_count         : vectors currently buffered
module systolic_skew_feeder
   import npu_pkg::*;
#(
   parameter int unsigned ELEM_W = npu_pkg::ELEM_W,
   parameter int unsigned ROWS   = npu_pkg::ROWS,
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned AWIDTH = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   s_valid,
   output logic                   s_ready,
   input  logic [ROWS*ELEM_W-1:0] s_data,
   input  logic                   s_last,
   input  logic                   start,
   output logic [ROWS*ELEM_W-1:0] row_data,
   output logic                   en_o,
   output logic                   busy,
   output logic                   done,
   output logic [AWIDTH:0]        vec_count
);

   localparam int unsigned VEC_W   = ROWS * ELEM_W;
   localparam int unsigned CNT_W   = AWIDTH + 1;
   localparam int unsigned FLUSH_N = 2 * ROWS - 1;
   localparam int unsigned FCNT_W  = $clog2(FLUSH_N + 1);

   feeder_state_t     state;
   logic [VEC_W-1:0]  mem [DEPTH];
   logic [CNT_W-1:0]  wr_cnt;
   logic [CNT_W-1:0]  rd_ptr;
   logic [FCNT_W-1:0] fcnt;
`ifdef FEEDER_REPLAY_EN
   logic              stale;
`endif

   logic              accept_c;
   logic              trig_c;
   logic [CNT_W-1:0]  base_c;
   logic [CNT_W-1:0]  wr_cnt_nxt;
   logic [VEC_W-1:0]  feed_c;

   // Handshake and write-count lookahead; base_c is where the next vector lands.
   always_comb begin
      accept_c = s_valid && s_ready;
      trig_c   = start || (accept_c && s_last);
`ifdef FEEDER_REPLAY_EN
      base_c   = (accept_c && stale) ? '0 : wr_cnt;
`else
      base_c   = wr_cnt;
`endif
      wr_cnt_nxt = accept_c ? base_c + 1'b1 : wr_cnt;
   end

   // Vector storage; no reset needed since wr_cnt bounds what is read.
   always_ff @(posedge clk) begin
      if (accept_c) mem[base_c[AWIDTH-1:0]] <= s_data;
   end

   // Batch sequencer with registered handshake and status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         wr_cnt  <= '0;
         rd_ptr  <= '0;
         fcnt    <= '0;
         s_ready <= 1'b1;
         en_o    <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
`ifdef FEEDER_REPLAY_EN
         stale   <= 1'b0;
`endif
      end else begin
         done   <= 1'b0;
         // en_o trails the state by the same one cycle as the row 0 register.
         en_o   <= (state == STREAM) || (state == FLUSH);
         wr_cnt <= wr_cnt_nxt;
         case (state)
            IDLE: begin
`ifdef FEEDER_REPLAY_EN
               if (accept_c && stale) stale <= 1'b0;
               s_ready <= (wr_cnt_nxt < CNT_W'(DEPTH)) || (stale && !accept_c);
`else
               s_ready <= (wr_cnt_nxt < CNT_W'(DEPTH));
`endif
               if (trig_c) begin
                  if (wr_cnt_nxt != '0) begin
                     state   <= STREAM;
                     rd_ptr  <= '0;
                     busy    <= 1'b1;
                     s_ready <= 1'b0;
                  end else begin
                     // Empty batch: nothing to stream, acknowledge immediately.
                     done <= 1'b1;
                  end
               end
            end
            STREAM: begin
               rd_ptr <= rd_ptr + 1'b1;
               if (rd_ptr + 1'b1 == wr_cnt) begin
                  state <= FLUSH;
                  fcnt  <= '0;
               end
            end
            FLUSH: begin
               fcnt <= fcnt + 1'b1;
               if (fcnt == FCNT_W'(FLUSH_N - 1)) state <= DONE_ST;
            end
            DONE_ST: begin
               state   <= IDLE;
               busy    <= 1'b0;
               done    <= 1'b1;
               s_ready <= 1'b1;
`ifdef FEEDER_REPLAY_EN
               stale   <= 1'b1;
`else
               wr_cnt  <= '0;
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Zeros outside STREAM provide the drain padding.
   assign feed_c    = (state == STREAM) ? mem[rd_ptr[AWIDTH-1:0]] : '0;
   assign vec_count = wr_cnt;

   // Row r sees its element r cycles later than row 0.
   for (genvar r = 0; r < int'(ROWS); r++) begin : g_row
      skew_delay #(
         .W     (ELEM_W),
         .DELAY (r)
      ) u_dly (
         .clk (clk),
         .rst (rst),
         .d   (feed_c[r*ELEM_W +: ELEM_W]),
         .q   (row_data[r*ELEM_W +: ELEM_W])
      );
   end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Self-checking bench for systolic_skew_feeder. Expected outputs come from a
// queue of buffered vectors and the skew rule row r at t = vec[t-r][r].
// Honours FEEDER_REPLAY_EN if the same define is given to the bench.
module tb_systolic_skew_feeder;

   localparam int ROWS  = 3;
   localparam int EW    = 8;
   localparam int DEPTH = 8;
   localparam int AW    = 3;
   localparam int VW    = ROWS * EW;
`ifdef FEEDER_REPLAY_EN
   localparam bit REPLAY = 1'b1;
`else
   localparam bit REPLAY = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          s_valid;
   logic          s_ready;
   logic [VW-1:0] s_data;
   logic          s_last;
   logic          start;
   logic [VW-1:0] row_data;
   logic          en_o;
   logic          busy;
   logic          done;
   logic [AW:0]   vec_count;

   int            n_assert = 0;
   int            n_fail   = 0;
   logic [VW-1:0] model_q[$];
   bit            stale_m  = 1'b0;
   bit            trig;

   always #5 clk = ~clk;

   systolic_skew_feeder dut (
      .clk       (clk),
      .rst       (rst),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_data    (s_data),
      .s_last    (s_last),
      .start     (start),
      .row_data  (row_data),
      .en_o      (en_o),
      .busy      (busy),
      .done      (done),
      .vec_count (vec_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one vector in the current cycle; model acceptance and triggering.
   task automatic push_cycle(input logic [VW-1:0] v, input bit last, input bit st, output bit trg);
      bit exp_rdy;
      s_valid = 1'b1;
      s_data  = v;
      s_last  = last;
      start   = st;
      @(negedge clk);
      exp_rdy = (model_q.size() < DEPTH) || stale_m;
      chk("s_ready push", 32'(s_ready), 32'(exp_rdy));
      chk("vec_count push", 32'(vec_count), 32'(model_q.size()));
      if (exp_rdy) begin
         if (stale_m) begin
            model_q.delete();
            stale_m = 1'b0;
         end
         model_q.push_back(v);
      end
      trg = st || (last && exp_rdy);
   endtask

   // Follow a batch triggered in the current cycle, checking every cycle after it.
   task automatic run_batch(input bit abuse);
      int            n;
      int            last_en;
      int            done_d;
      int            t;
      logic [VW-1:0] exp_row;
      logic [VW-1:0] tmp;
      bit            exp_en, exp_busy, exp_done, exp_rdy;
      int            exp_cnt;
      n       = model_q.size();
      last_en = n + 2 * ROWS;
      done_d  = (n == 0) ? 1 : last_en + 1;
      for (int d = 1; d <= last_en + 2; d++) begin
         tick();
         start   = abuse && (d == 3);
         s_valid = abuse && (d <= last_en);
         s_last  = 1'b0;
         s_data  = VW'($urandom);
         @(negedge clk);
         t       = d - 2;
         exp_row = '0;
         for (int r = 0; r < ROWS; r++) begin
            if (t - r >= 0 && t - r < n) begin
               tmp = model_q[t-r];
               exp_row[r*EW +: EW] = tmp[r*EW +: EW];
            end
         end
         exp_en   = (n > 0) && (t >= 0) && (t < n + 2 * ROWS - 1);
         exp_busy = (n > 0) && (d <= last_en);
         exp_done = (d == done_d);
         exp_cnt  = (n > 0 && d >= done_d && !REPLAY) ? 0 : n;
         exp_rdy  = !((n > 0) && (d <= last_en));
         chk($sformatf("row_data n=%0d d=%0d", n, d), 32'(row_data), 32'(exp_row));
         chk($sformatf("en_o n=%0d d=%0d", n, d), 32'(en_o), 32'(exp_en));
         chk($sformatf("busy n=%0d d=%0d", n, d), 32'(busy), 32'(exp_busy));
         chk($sformatf("done n=%0d d=%0d", n, d), 32'(done), 32'(exp_done));
         chk($sformatf("vec_count n=%0d d=%0d", n, d), 32'(vec_count), 32'(exp_cnt));
         chk($sformatf("s_ready n=%0d d=%0d", n, d), 32'(s_ready), 32'(exp_rdy));
      end
      start   = 1'b0;
      s_valid = 1'b0;
      if (n > 0) begin
         if (REPLAY) stale_m = 1'b1;
         else model_q.delete();
      end
   endtask

   initial begin
      rst     = 1'b1;
      s_valid = 1'b0;
      s_last  = 1'b0;
      start   = 1'b0;
      s_data  = '0;

      // Reset values
      tick();
      @(negedge clk);
      chk("reset row_data", 32'(row_data), 32'h0);
      chk("reset en_o", 32'(en_o), 32'h0);
      chk("reset busy", 32'(busy), 32'h0);
      chk("reset done", 32'(done), 32'h0);
      chk("reset vec_count", 32'(vec_count), 32'h0);
      chk("reset s_ready", 32'(s_ready), 32'h1);
      tick();
      rst = 1'b0;

      // Empty start: done one cycle later, no enable
      start = 1'b1;
      run_batch(1'b0);

      // Basic skew, batch closed by s_last
      tick();
      push_cycle(24'h030201, 1'b0, 1'b0, trig);
      tick();
      push_cycle(24'h060504, 1'b1, 1'b0, trig);
      chk("basic s_last trigger", 32'(trig), 32'h1);
      run_batch(1'b0);

      // Second start: replay of the same batch, or an empty start
      tick();
      start = 1'b1;
      run_batch(1'b0);

      // Full buffer: ninth vector refused
      tick();
      for (int i = 0; i < DEPTH + 1; i++) begin
         push_cycle(VW'($urandom), 1'b0, 1'b0, trig);
         tick();
      end
      s_valid = 1'b0;
      start   = 1'b1;
      run_batch(1'b0);

      // Backpressure: vectors and start during the batch are ignored
      tick();
      for (int i = 0; i < 3; i++) begin
         push_cycle(VW'($urandom), 1'b0, 1'b0, trig);
         tick();
      end
      s_valid = 1'b0;
      start   = 1'b1;
      run_batch(1'b1);

      // Start and valid together: the vector joins the batch
      tick();
      push_cycle(VW'($urandom), 1'b0, 1'b0, trig);
      tick();
      push_cycle(VW'($urandom), 1'b0, 1'b1, trig);
      run_batch(1'b0);

      // Reset in STREAM cycle 1 aborts the batch without done
      tick();
      for (int i = 0; i < 3; i++) begin
         push_cycle(VW'($urandom), 1'b0, 1'b0, trig);
         tick();
      end
      s_valid = 1'b0;
      start   = 1'b1;
      tick();
      start = 1'b0;
      tick();
      rst = 1'b1;
      @(negedge clk);
      chk("pre-reset en_o", 32'(en_o), 32'h1);
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("abort row_data", 32'(row_data), 32'h0);
      chk("abort en_o", 32'(en_o), 32'h0);
      chk("abort busy", 32'(busy), 32'h0);
      chk("abort vec_count", 32'(vec_count), 32'h0);
      chk("abort done", 32'(done), 32'h0);
      chk("abort s_ready", 32'(s_ready), 32'h1);
      model_q.delete();
      stale_m = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         @(negedge clk);
         chk($sformatf("post-abort done c=%0d", i), 32'(done), 32'h0);
         chk($sformatf("post-abort en_o c=%0d", i), 32'(en_o), 32'h0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
